// File: rtl/pipelined_predecoder.sv
// pipelined_predecoder: two-stage hierarchical word-line decoder with valid/ready
// handshakes. Stage 1 one-hot predecodes each PRE_WIDTH-bit address group. Stage 2
// ANDs one bit from each group vector into a 2**ADDR_WIDTH one-hot word select.
// Optional feature macro: PREDECODER_ADDR_PARITY_EN. It adds even-parity checking
// of the address, using the input_parity input and the parity_error output.
module pipelined_predecoder #(
    parameter int ADDR_WIDTH = 6,
    parameter int PRE_WIDTH  = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      input_address,
    input  logic                       decode_enable,
`ifdef PREDECODER_ADDR_PARITY_EN
    input  logic                       input_parity,
    output logic                       parity_error,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2**ADDR_WIDTH-1:0]   decoded_output
);

    localparam int GROUPS   = ADDR_WIDTH / PRE_WIDTH;
    localparam int PRE_SIZE = 2 ** PRE_WIDTH;
    localparam int WORDS    = 2 ** ADDR_WIDTH;
    localparam logic [PRE_SIZE-1:0] PRE_ONE = PRE_SIZE'(1);

    generate
        if (ADDR_WIDTH % PRE_WIDTH != 0) begin : g_bad_width
            $error("pipelined_predecoder: ADDR_WIDTH must be a multiple of PRE_WIDTH");
        end
    endgenerate

    logic                             s1_valid;
    logic [GROUPS-1:0][PRE_SIZE-1:0]  s1_pre;
    logic [GROUPS-1:0][PRE_SIZE-1:0]  pre_next;
    logic [WORDS-1:0]                 word_next;
    logic                             adv1;
    logic                             adv2;
    logic                             addr_ok;

    // Handshake: a stage advances when it is empty or its consumer is taking data.
    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

`ifdef PREDECODER_ADDR_PARITY_EN
    logic s1_perr;
    assign addr_ok = ~(^{input_address, input_parity});
`else
    assign addr_ok = 1'b1;
`endif

    // Stage-1 predecode: one-hot per group, zeroed when disabled or on a parity error.
    always_comb begin
        pre_next = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (decode_enable && addr_ok)
                pre_next[g] = PRE_ONE << input_address[g*PRE_WIDTH +: PRE_WIDTH];
        end
    end

    // Stage-1 register: bubbles are overwritten whenever the stage can advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_pre   <= '0;
`ifdef PREDECODER_ADDR_PARITY_EN
            s1_perr  <= 1'b0;
`endif
        end else if (adv1) begin
            s1_valid <= in_valid;
            s1_pre   <= pre_next;
`ifdef PREDECODER_ADDR_PARITY_EN
            s1_perr  <= ~addr_ok;
`endif
        end
    end

    // Stage-2 combine: word i is selected when every group vector has i's group bit set.
    always_comb begin
        logic                  hit;
        logic [ADDR_WIDTH-1:0] idx;
        hit       = 1'b0;
        idx       = '0;
        word_next = '0;
        for (int i = 0; i < WORDS; i++) begin
            idx = ADDR_WIDTH'(i);
            hit = 1'b1;
            for (int g = 0; g < GROUPS; g++)
                hit = hit & s1_pre[g][idx[g*PRE_WIDTH +: PRE_WIDTH]];
            word_next[i] = hit;
        end
    end

    // Stage-2 register: output holds under stall and keeps its last word across bubbles.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid      <= 1'b0;
            decoded_output <= '0;
`ifdef PREDECODER_ADDR_PARITY_EN
            parity_error   <= 1'b0;
`endif
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                decoded_output <= word_next;
`ifdef PREDECODER_ADDR_PARITY_EN
                parity_error   <= s1_perr;
`endif
            end
        end
    end

endmodule
